data_mem_bhw: RTL

- Byte-addressable, parametrised data memory for the femtoRV32 load/store path.
- Supports RV32 byte, halfword and word accesses with sign or zero extension, and flags misaligned or illegal accesses.
- Uses a request/response handshake with configurable access latency, so the core can model slower memories.
- Sits between the execute stage and the memory array and replaces the fixed 64-word, word-only memory.

---
 rtl/data_mem_bhw.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_bhw.sv
// Byte-addressable data memory for the femtoRV32 load/store path.
// Request/response handshake:
//   A request is accepted on a rising edge where req_valid && req_ready.
//   req_ready is high only in IDLE. The response is a single-cycle
//   rsp_valid pulse LATENCY cycles after the accept cycle. The consumer
//   cannot stall the response. Requests seen while req_ready is low are
//   dropped.
// Store write and load read both happen on the accept edge. The result
// is copied into rsp_rdata/rsp_err when RESP is entered and held there
// until the next response.
module data_mem_bhw #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        state_dbg
);

    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              accept, enter_resp;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        byte_off;

    logic              legal, aligned, err;
    logic [31:0]       rd_word, load_data;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [3:0]        be;
    logic [31:0]       wr_lane;
    logic [31:0]       hold_rdata;
    logic              hold_err;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign byte_off = req_addr[1:0];

    // Access decode: legality of funct3 for the direction, and alignment.
    always_comb begin
        aligned = 1'b0;
        legal   = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~byte_off[0];
            3'b010:         aligned = (byte_off == 2'b00);
            default:        aligned = 1'b0;
        endcase
        if (req_we)
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        err = ~(legal & aligned);
    end

    // Load path: pick byte/halfword lane and extend; zero for stores and errors.
    always_comb begin
        rd_word   = mem[word_idx];
        rd_byte   = rd_word[8*byte_off +: 8];
        rd_half   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'd0;
        if (!err && !req_we) begin
            case (req_funct3)
                3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  load_data = {24'd0, rd_byte};
                3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                3'b101:  load_data = {16'd0, rd_half};
                3'b010:  load_data = rd_word;
                default: load_data = 32'd0;
            endcase
        end
    end

    // Store path: byte enables from size and offset, data replicated per lane.
    always_comb begin
        be      = 4'b0000;
        wr_lane = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << byte_off;
                wr_lane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be      = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be      = 4'b1111;
                wr_lane = req_wdata;
            end
            default: begin
                be      = 4'b0000;
                wr_lane = req_wdata;
            end
        endcase
    end

    // Memory array write on the accept edge; illegal stores never write.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[word_idx][8*k +: 8] <= wr_lane[8*k +: 8];
            end
        end
    end

    // FSM next state, latency counter and handshake outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = req_valid && (state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // The response cycle starts when the counter reaches zero.
                cnt_next = cnt - 1'b1;
                if (cnt <= CNT_W'(1)) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        enter_resp = (state_next == RESP) && (state != RESP);
        req_ready  = (state == IDLE);
        rsp_valid  = (state == RESP);
        state_dbg  = state;
    end

    // State, counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_rdata <= 32'd0;
            hold_err   <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                hold_rdata <= load_data;
                hold_err   <= err;
            end
            if (enter_resp) begin
                rsp_rdata <= accept ? load_data : hold_rdata;
                rsp_err   <= accept ? err : hold_err;
            end
        end
    end

endmodule
